alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Handshaked, multi-cycle successor to the combinational execute ALU.
- Accepts one operation per transaction on a valid/ready input and returns the result on a valid/ready output.
- Add/logic/compare ops complete in one cycle; shifts run on an iterative shifter that moves SHIFT_STEP bits per cycle.
- Corrects unsigned compares, masks shift amounts, and carries a destination tag. Sits between decode/issue and writeback.

Parameters:
- DATA_WIDTH, 32, operand/result width; power of two, >= 8.
- SHIFT_STEP, 4, bits shifted per iteration; power of two, 1..DATA_WIDTH.
- TAG_WIDTH, 5, width of the opaque tag carried from input to output (e.g. rd index).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  abort in-flight op and drop any pending result
- in_valid_i  in  1  operation offered
- in_ready_o  out  1  operation can be accepted
- operator_i  in  alu_opcode_e  operation
- operand_a_i  in  DATA_WIDTH  operand A
- operand_b_i  in  DATA_WIDTH  operand B
- tag_i  in  TAG_WIDTH  opaque tag
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer takes result
- result_o  out  DATA_WIDTH  result
- tag_o  out  TAG_WIDTH  tag of result

Behaviour:
- Clock is clk_i. Reset rst_i is synchronous and active-high.
- On reset: state=IDLE, out_valid_o=0, result_o=0, tag_o=0, in_ready_o=1 (the cycle after reset).
- Acceptance: an operation is accepted on a rising edge where in_valid_i && in_ready_o.
- in_ready_o is 1 when state=IDLE, or when state=DONE && out_ready_i (back-to-back throughput).
- FSM IDLE:
  - On accept of a non-shift op, or a shift with shamt=0: register result and tag, go to DONE.
  - On accept of a shift with shamt>0: latch operand A, shamt, op and tag into working registers, go to SHIFT.
- FSM SHIFT:
  - Each cycle, shift the working value by min(SHIFT_STEP, remaining) and subtract that amount from remaining.
  - When remaining <= SHIFT_STEP, the shifted value goes to result_o and state goes to DONE on that edge.
- FSM DONE:
  - out_valid_o=1, and result_o/tag_o are held stable until out_ready_i.
  - On out_ready_i: accept a new op if offered (follow the IDLE rules), otherwise go to IDLE.
- Latency: accept at edge N.
  - Single-cycle ops and shamt=0: out_valid_o high after edge N+1.
  - Shifts with shamt>0: out_valid_o high after edge N+1+ceil(shamt/SHIFT_STEP).
- Shift amount: shamt = operand_b_i[$clog2(DATA_WIDTH)-1:0]; upper bits of B are ignored.
  - SRA fills with the sign bit of the original A at every step.
  - SLL and SRL fill with 0.
- Add/sub:
  - ADD/ADDU give A+B, SUB/SUBU give A-B, both modulo 2^DATA_WIDTH.
  - No flags, no overflow trap.
- Logic ops: AND/OR/XOR are bitwise.
- Compares: result is zero-extended 1 bit in result_o[0].
  - SLT/LES/GTS/GES compare signed.
  - SLTU/LEU/GTU/GEU compare unsigned.
  - EQ/NE compare equality.
- Unknown opcode: result 0, completes in one cycle.
- Flush: flush_i in any state forces IDLE and out_valid_o=0 on the next edge, and no op is accepted that edge. in_ready_o is 0 while flush_i is 1.
- Priority: rst_i > flush_i > normal operation.
- Reset or flush mid-shift discards the working registers with no output.
- Inputs are sampled only at acceptance; changes on operand/op/tag inputs while busy have no effect.

Decomposition:
- toothless_pkg:
  - Existing alu_opcode_e.
  - New alu_seq_state_e {IDLE, SHIFT, DONE}.
  - Helper function is_shift_op(alu_opcode_e).
- One sub-module, alu_shift_step: combinational shifter taking value, amount (0..SHIFT_STEP), direction and arithmetic fill, and returning the shifted value.
- The single-cycle datapath stays inline.

Test Plan (DATA_WIDTH=32, SHIFT_STEP=4, out_ready_i=1 unless stated):
- SLTU A=0xFFFFFFFF, B=1 -> result 0. SLT with the same operands -> result 1. Both appear one cycle after accept.
- SLL A=1, B=5 -> result 0x20, out_valid_o three cycles after accept. SLL A=1, B=0x25 (masked shamt 5) -> same result and timing.
- SRA A=0x80000000, B=31 -> 0xFFFFFFFF after 9 cycles. SRL with the same operands -> 0x00000001.
- Backpressure: ADD 7+(-3) with out_ready_i=0 for 5 cycles -> result 4 and tag held stable, in_ready_o=0. Release with a new op offered -> new op accepted on the same edge, next result one cycle later.
- Back-to-back: stream of 4 XOR ops with in_valid_i and out_ready_i held high -> one result per cycle, tags in order.
- Flush at the 2nd SHIFT cycle of SLL B=20 -> IDLE next edge, no out_valid_o. Repeat with rst_i -> same, and all outputs read 0.

Source files
------------

// File: rtl/toothless_pkg.sv
// Shared ALU types: opcode encoding, sequential-ALU FSM states and opcode helpers.
// Pure declarations; no timing or flow control.
package toothless_pkg;

  typedef enum logic [5:0] {
    ALU_ADD  = 6'd0,
    ALU_SUB  = 6'd1,
    ALU_ADDU = 6'd2,
    ALU_SUBU = 6'd3,
    ALU_XOR  = 6'd4,
    ALU_OR   = 6'd5,
    ALU_AND  = 6'd6,
    ALU_SRA  = 6'd7,
    ALU_SRL  = 6'd8,
    ALU_SLL  = 6'd9,
    ALU_SLT  = 6'd10,
    ALU_SLTU = 6'd11,
    ALU_LES  = 6'd12,
    ALU_LEU  = 6'd13,
    ALU_GTS  = 6'd14,
    ALU_GTU  = 6'd15,
    ALU_GES  = 6'd16,
    ALU_GEU  = 6'd17,
    ALU_EQ   = 6'd18,
    ALU_NE   = 6'd19
  } alu_opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_seq_state_e;

  function automatic logic is_shift_op(alu_opcode_e op);
    return (op == ALU_SRA) || (op == ALU_SRL) || (op == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the iterative shifter: shifts value by amount with a caller-chosen fill bit.
// Latency: combinational. Backpressure: none.
module alu_shift_step #(
  parameter int DATA_WIDTH = 32,
  parameter int AMT_W      = 6
) (
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [AMT_W-1:0]      amount,
  input  logic                  left,
  input  logic                  fill,
  output logic [DATA_WIDTH-1:0] shifted
);

  logic [DATA_WIDTH-1:0] fill_mask;

  always_comb begin
    fill_mask = '0;
    if (fill) begin
      fill_mask = ~({DATA_WIDTH{1'b1}} >> amount);
    end
    if (left) begin
      shifted = value << amount;
    end else begin
      shifted = (value >> amount) | fill_mask;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle arithmetic/logic/compare, iterative SHIFT_STEP-bit shifter.
// Latency: 1 cycle, or 1+ceil(shamt/SHIFT_STEP) for shifts. Backpressure: result held in DONE until out_ready_i.
module alu_seq import toothless_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 4,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  alu_opcode_e           operator_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [TAG_WIDTH-1:0]  tag_o
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam logic [SHAMT_W:0] STEP_AMT = (SHAMT_W+1)'(SHIFT_STEP);

  alu_seq_state_e        state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, work_q, alu_res, step_out;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [SHAMT_W-1:0]    rem_q, shamt;
  logic [SHAMT_W:0]      step_amt;
  logic                  left_q, fill_q;
  logic                  accept, start_shift, last_step;

  assign in_ready_o  = !flush_i && ((state_q == IDLE) || ((state_q == DONE) && out_ready_i));
  assign accept      = in_valid_i && in_ready_o;
  assign shamt       = operand_b_i[SHAMT_W-1:0];
  assign start_shift = is_shift_op(operator_i) && (shamt != '0);
  assign last_step   = {1'b0, rem_q} <= STEP_AMT;
  assign step_amt    = last_step ? {1'b0, rem_q} : STEP_AMT;

  assign out_valid_o = (state_q == DONE);
  assign result_o    = result_q;
  assign tag_o       = tag_q;

  // Shift ops land here only when shamt is zero, so they pass A through.
  always_comb begin
    alu_res = '0;
    case (operator_i)
      ALU_ADD, ALU_ADDU:         alu_res = operand_a_i + operand_b_i;
      ALU_SUB, ALU_SUBU:         alu_res = operand_a_i - operand_b_i;
      ALU_XOR:                   alu_res = operand_a_i ^ operand_b_i;
      ALU_OR:                    alu_res = operand_a_i | operand_b_i;
      ALU_AND:                   alu_res = operand_a_i & operand_b_i;
      ALU_SRA, ALU_SRL, ALU_SLL: alu_res = operand_a_i;
      ALU_SLT:  alu_res[0] = $signed(operand_a_i) <  $signed(operand_b_i);
      ALU_SLTU: alu_res[0] = operand_a_i <  operand_b_i;
      ALU_LES:  alu_res[0] = $signed(operand_a_i) <= $signed(operand_b_i);
      ALU_LEU:  alu_res[0] = operand_a_i <= operand_b_i;
      ALU_GTS:  alu_res[0] = $signed(operand_a_i) >  $signed(operand_b_i);
      ALU_GTU:  alu_res[0] = operand_a_i >  operand_b_i;
      ALU_GES:  alu_res[0] = $signed(operand_a_i) >= $signed(operand_b_i);
      ALU_GEU:  alu_res[0] = operand_a_i >= operand_b_i;
      ALU_EQ:   alu_res[0] = operand_a_i == operand_b_i;
      ALU_NE:   alu_res[0] = operand_a_i != operand_b_i;
      default:  alu_res = '0;
    endcase
  end

  alu_shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .AMT_W      (SHAMT_W+1)
  ) u_shift_step (
    .value   (work_q),
    .amount  (step_amt),
    .left    (left_q),
    .fill    (fill_q),
    .shifted (step_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = start_shift ? SHIFT : DONE;
      SHIFT:   if (last_step) state_d = DONE;
      DONE: begin
        if (out_ready_i) begin
          state_d = accept ? (start_shift ? SHIFT : DONE) : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      result_q <= '0;
      tag_q    <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      left_q   <= 1'b0;
      fill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tag_q <= tag_i;
        if (start_shift) begin
          work_q <= operand_a_i;
          rem_q  <= shamt;
          left_q <= (operator_i == ALU_SLL);
          // SRA fill is the original sign, fixed for every step.
          fill_q <= (operator_i == ALU_SRA) && operand_a_i[DATA_WIDTH-1];
        end else begin
          result_q <= alu_res;
        end
      end else if ((state_q == SHIFT) && !flush_i) begin
        work_q <= step_out;
        rem_q  <= rem_q - step_amt[SHAMT_W-1:0];
        if (last_step) result_q <= step_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results queued at accept, checked at output handshake.
module tb_alu_seq;
  import toothless_pkg::*;

  localparam int DW = 32;
  localparam int TW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i, in_valid_i, in_ready_o;
  alu_opcode_e   operator_i;
  logic [DW-1:0] operand_a_i, operand_b_i, result_o;
  logic [TW-1:0] tag_i, tag_o;
  logic          out_valid_o, out_ready_i;

  always #5 clk_i = ~clk_i;

  alu_seq #(
    .DATA_WIDTH (DW),
    .SHIFT_STEP (4),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .operator_i  (operator_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .tag_o       (tag_o)
  );

  typedef struct packed {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Call between a negedge and the following posedge; returns at the negedge after acceptance.
  task automatic issue(input alu_opcode_e op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] tag, input logic push, input logic [DW-1:0] res,
                       output int waits);
    logic rdy;
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    tag_i       = tag;
    in_valid_i  = 1'b1;
    waits       = 0;
    rdy         = 1'b0;
    while (!rdy && waits < 50) begin
      #1;
      rdy = in_ready_o;
      @(posedge clk_i);
      if (!rdy) begin
        waits++;
        @(negedge clk_i);
      end
    end
    if (!rdy) chk("accept_timeout", {63'd0, in_ready_o}, 64'd1);
    else if (push) sb.push_back({res, tag});
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic run_op(input string name, input alu_opcode_e op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [TW-1:0] tag,
                        input logic [DW-1:0] res, input int exp_lat);
    int w, lat;
    issue(op, a, b, tag, 1'b1, res, w);
    lat = 1;
    #1;
    while (!out_valid_o && lat < 40) begin
      @(negedge clk_i);
      #1;
      lat++;
    end
    chk({name, "_lat"}, lat, exp_lat);
    @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    #2;
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", {63'd0, out_valid_o}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", result_o, mon_e.res);
        chk("tag", tag_o, mon_e.tag);
      end
    end
  end

  initial begin
    int            w, seen;
    logic [DW-1:0] xa, xe;
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    operator_i  = ALU_ADD;
    operand_a_i = '0;
    operand_b_i = '0;
    tag_i       = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_ready", in_ready_o, 1);
    @(negedge clk_i);

    run_op("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'd1,    5'd1,  32'd0,         1);
    run_op("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'd1,    5'd2,  32'd1,         1);
    run_op("sll5",     ALU_SLL,  32'd1,         32'd5,    5'd3,  32'h20,        3);
    run_op("sll_mask", ALU_SLL,  32'd1,         32'h25,   5'd4,  32'h20,        3);
    run_op("sra31",    ALU_SRA,  32'h8000_0000, 32'd31,   5'd5,  32'hFFFF_FFFF, 9);
    run_op("srl31",    ALU_SRL,  32'h8000_0000, 32'd31,   5'd6,  32'd1,         9);
    run_op("sll0",     ALU_SLL,  32'h1234,      32'h40,   5'd7,  32'h1234,      1);
    run_op("sra7",     ALU_SRA,  32'hF000_0000, 32'd7,    5'd8,  32'hFFE0_0000, 3);
    run_op("geu",      ALU_GEU,  32'd5,         32'd5,    5'd9,  32'd1,         1);
    run_op("ne",       ALU_NE,   32'd5,         32'd5,    5'd10, 32'd0,         1);
    run_op("gts",      ALU_GTS,  32'hFFFF_FFFF, 32'd0,    5'd11, 32'd0,         1);
    run_op("unknown",  alu_opcode_e'(6'h3F), 32'd1, 32'd1, 5'd12, 32'd0,        1);

    // Backpressure: result must hold while a new op waits
    out_ready_i = 1'b0;
    issue(ALU_ADD, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1, 32'd4, w);
    operator_i  = ALU_SUB;
    operand_a_i = 32'd10;
    operand_b_i = 32'd4;
    tag_i       = 5'd4;
    in_valid_i  = 1'b1;
    repeat (5) begin
      #1;
      chk("hold_valid", out_valid_o, 1);
      chk("hold_result", result_o, 32'd4);
      chk("hold_tag", tag_o, 5'd3);
      chk("hold_ready", in_ready_o, 0);
      @(negedge clk_i);
    end
    out_ready_i = 1'b1;
    #1;
    chk("release_ready", in_ready_o, 1);
    @(posedge clk_i);
    sb.push_back({32'd6, 5'd4});
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    chk("release_next_valid", out_valid_o, 1);
    @(negedge clk_i);

    // Back-to-back XOR stream
    for (int i = 0; i < 4; i++) begin
      xa = 32'h1111 * (i + 1);
      xe = xa ^ 32'hF0F0_F0F0;
      issue(ALU_XOR, xa, 32'hF0F0_F0F0, 5'(16 + i), 1'b1, xe, w);
      chk("b2b_wait", w, 0);
    end
    @(negedge clk_i);

    // Flush in the second SHIFT cycle, with another op offered
    issue(ALU_SLL, 32'd1, 32'd20, 5'd13, 1'b0, 32'd0, w);
    @(negedge clk_i);
    flush_i     = 1'b1;
    operator_i  = ALU_ADD;
    tag_i       = 5'd14;
    in_valid_i  = 1'b1;
    #1;
    chk("flush_ready", in_ready_o, 0);
    @(negedge clk_i);
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    #1;
    chk("flush_valid", out_valid_o, 0);
    chk("flush_idle_ready", in_ready_o, 1);
    seen = 0;
    repeat (8) begin
      @(negedge clk_i);
      #1;
      if (out_valid_o) seen++;
    end
    chk("flush_no_out", seen, 0);
    @(negedge clk_i);

    // Same with reset: all outputs return to zero
    issue(ALU_SLL, 32'd1, 32'd20, 5'd15, 1'b0, 32'd0, w);
    @(negedge clk_i);
    rst_i      = 1'b1;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    #1;
    chk("rst2_valid", out_valid_o, 0);
    chk("rst2_result", result_o, 0);
    chk("rst2_tag", tag_o, 0);
    chk("rst2_ready", in_ready_o, 1);
    seen = 0;
    repeat (8) begin
      @(negedge clk_i);
      #1;
      if (out_valid_o) seen++;
    end
    chk("rst2_no_out", seen, 0);

    repeat (3) @(negedge clk_i);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
